// File: rtl/micro_sequencer_pkg.sv
// Shared encodings for the microprogram sequencer: address-control field,
// micro-state numbers, opcodes and dispatch-table selection.
package micro_pkg;

   localparam logic [1:0] ADDR_FETCH = 2'b00;
   localparam logic [1:0] ADDR_DISP1 = 2'b01;
   localparam logic [1:0] ADDR_DISP2 = 2'b10;
   localparam logic [1:0] ADDR_SEQ   = 2'b11;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   typedef enum logic {
      TBL_DISP1 = 1'b0,
      TBL_DISP2 = 1'b1
   } table_sel_e;

endpackage

// File: rtl/micro_sequencer_if.sv
// Sequencer bus: ROM/IR inputs toward the sequencer, micro-state and status back.
interface micro_sequencer_if #(
   parameter int CNT_W = 16
);
   logic [1:0]       addr_ctl;
   logic [5:0]       opcode;
   logic             stall;
   logic             clear_err;
   logic [3:0]       state;
   logic             instr_done;
   logic             illegal_op;
   logic [CNT_W-1:0] retired_count;

   modport master (
      output addr_ctl, opcode, stall, clear_err,
      input  state, instr_done, illegal_op, retired_count
   );

   modport slave (
      input  addr_ctl, opcode, stall, clear_err,
      output state, instr_done, illegal_op, retired_count
   );
endinterface

// File: rtl/micro_sequencer_dispatch_rom.sv
// Two opcode dispatch tables; valid=0 marks an opcode with no entry.
module dispatch_rom
   import micro_pkg::*;
(
   input  logic [5:0] opcode,
   input  table_sel_e table_sel,
   output logic [3:0] target,
   output logic       valid
);

   always_comb begin
      target = S_FETCH;
      valid  = 1'b1;
      if (table_sel == TBL_DISP1) begin
         case (opcode)
            OP_LW, OP_SW: target = S_MEMADR;
            OP_RTYPE:     target = S_EXEC;
            OP_BEQ:       target = S_BRANCH;
            OP_J:         target = S_JUMP;
            default:      valid  = 1'b0;
         endcase
      end else begin
         case (opcode)
            OP_LW:   target = S_MEMRD;
            OP_SW:   target = S_MEMWR;
            default: valid  = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-state register, next-state selection, sticky error flag, completion
// pulse and saturating retired-instruction counter.
module micro_sequencer
   import micro_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   micro_sequencer_if.slave  bus
);

   logic [3:0]       state_q;
   logic [3:0]       next_state;
   logic             instr_done_q;
   logic             illegal_q;
   logic [CNT_W-1:0] count_q;
   logic             retire;
   logic             seq_err;
   table_sel_e       table_sel;
   logic [3:0]       rom_target;
   logic             rom_valid;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign table_sel = (bus.addr_ctl == ADDR_DISP2) ? TBL_DISP2 : TBL_DISP1;

   dispatch_rom u_dispatch_rom (
      .opcode    (bus.opcode),
      .table_sel (table_sel),
      .target    (rom_target),
      .valid     (rom_valid)
   );

   // Stall freezes sequencing entirely, so no retire or error can arise in it.
   always_comb begin
      next_state = state_q;
      retire     = 1'b0;
      seq_err    = 1'b0;
      if (!bus.stall) begin
         case (bus.addr_ctl)
            ADDR_FETCH: begin
               next_state = S_FETCH;
               retire     = (state_q != S_FETCH);
            end
            ADDR_DISP1, ADDR_DISP2: begin
               next_state = rom_valid ? rom_target : S_FETCH;
               seq_err    = !rom_valid;
            end
            default: begin
               if (state_q == 4'hF) begin
                  next_state = S_FETCH;
                  seq_err    = 1'b1;
               end else begin
                  next_state = state_q + 4'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         instr_done_q <= 1'b0;
         illegal_q    <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= next_state;
         instr_done_q <= retire;
         if (retire)
            count_q <= sat_inc(count_q);
         // A new error outranks a simultaneous clear.
         if (seq_err)
            illegal_q <= 1'b1;
         else if (bus.clear_err)
            illegal_q <= 1'b0;
      end
   end

   assign bus.state         = state_q;
   assign bus.instr_done    = instr_done_q;
   assign bus.illegal_op    = illegal_q;
   assign bus.retired_count = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench: directed steps queue hand-computed post-edge expectations,
// a monitor pops and compares after every rising edge.
module tb_micro_sequencer;
   import micro_pkg::*;

   localparam int CW = 4;

   typedef struct {
      logic [3:0]    s;
      logic          d;
      logic          i;
      logic [CW-1:0] c;
   } exp_t;

   logic clk;
   logic rst_n;
   logic seq_force;
   int   tests;
   int   fails;
   int   nstep;
   logic [CW-1:0] exp_cnt;
   exp_t q[$];

   micro_sequencer_if #(.CNT_W(CW)) bus ();

   micro_sequencer #(.CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Microcode ROM address-control column; seq_force walks the state space.
   function automatic logic [1:0] rom(input logic [3:0] s);
      case (s)
         4'd0, 4'd3, 4'd6: return ADDR_SEQ;
         4'd1:             return ADDR_DISP1;
         4'd2:             return ADDR_DISP2;
         default:          return ADDR_FETCH;
      endcase
   endfunction

   always_comb begin
      bus.addr_ctl = seq_force ? ADDR_SEQ : rom(bus.state);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge: drive inputs for the next edge, queue what follows it.
   task automatic step(input logic [5:0] op, input logic st, input logic clr,
                       input logic [3:0] es, input logic ed, input logic ei);
      exp_t e;
      bus.opcode    = op;
      bus.stall     = st;
      bus.clear_err = clr;
      if (ed && exp_cnt != 4'hF)
         exp_cnt = exp_cnt + 4'd1;
      e.s = es; e.d = ed; e.i = ei; e.c = exp_cnt;
      q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            nstep++;
            chk($sformatf("state@%0d", nstep), bus.state, e.s);
            chk($sformatf("done@%0d", nstep), bus.instr_done, e.d);
            chk($sformatf("illegal@%0d", nstep), bus.illegal_op, e.i);
            chk($sformatf("count@%0d", nstep), bus.retired_count, e.c);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      tests = 0; fails = 0; nstep = 0; exp_cnt = '0;
      seq_force = 1'b0;
      rst_n = 1'b0;
      bus.opcode = OP_LW; bus.stall = 1'b0; bus.clear_err = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_state", bus.state, 4'd0);
      chk("reset_done", bus.instr_done, 1'b0);
      chk("reset_illegal", bus.illegal_op, 1'b0);
      chk("reset_count", bus.retired_count, 4'd0);
      rst_n = 1'b1;

      // lw: 0,1,2,3,4,0
      step(OP_LW, 0, 0, 4'd1, 0, 0);
      step(OP_LW, 0, 0, 4'd2, 0, 0);
      step(OP_LW, 0, 0, 4'd3, 0, 0);
      step(OP_LW, 0, 0, 4'd4, 0, 0);
      step(OP_LW, 0, 0, 4'd0, 1, 0);
      // sw, R-type, beq, j back to back: 14 cycles
      step(OP_SW, 0, 0, 4'd1, 0, 0);
      step(OP_SW, 0, 0, 4'd2, 0, 0);
      step(OP_SW, 0, 0, 4'd5, 0, 0);
      step(OP_SW, 0, 0, 4'd0, 1, 0);
      step(OP_RTYPE, 0, 0, 4'd1, 0, 0);
      step(OP_RTYPE, 0, 0, 4'd6, 0, 0);
      step(OP_RTYPE, 0, 0, 4'd7, 0, 0);
      step(OP_RTYPE, 0, 0, 4'd0, 1, 0);
      step(OP_BEQ, 0, 0, 4'd1, 0, 0);
      step(OP_BEQ, 0, 0, 4'd8, 0, 0);
      step(OP_BEQ, 0, 0, 4'd0, 1, 0);
      step(OP_J, 0, 0, 4'd1, 0, 0);
      step(OP_J, 0, 0, 4'd9, 0, 0);
      step(OP_J, 0, 0, 4'd0, 1, 0);
      // lw with three stall cycles in state 3: 8 cycles total
      step(OP_LW, 0, 0, 4'd1, 0, 0);
      step(OP_LW, 0, 0, 4'd2, 0, 0);
      step(OP_LW, 0, 0, 4'd3, 0, 0);
      step(OP_LW, 1, 0, 4'd3, 0, 0);
      step(OP_LW, 1, 0, 4'd3, 0, 0);
      step(OP_LW, 1, 0, 4'd3, 0, 0);
      step(OP_LW, 0, 0, 4'd4, 0, 0);
      step(OP_LW, 0, 0, 4'd0, 1, 0);
      // illegal DISP1, then clear colliding with a second illegal, then clear
      step(6'h3F, 0, 0, 4'd1, 0, 0);
      step(6'h3F, 0, 0, 4'd0, 0, 1);
      step(6'h3F, 0, 0, 4'd1, 0, 1);
      step(6'h3F, 0, 1, 4'd0, 0, 1);
      step(6'h3F, 0, 1, 4'd1, 0, 0);
      step(6'h3F, 0, 0, 4'd0, 0, 1);
      // illegal DISP2 (opcode changes to beq in state 2)
      step(OP_LW, 0, 0, 4'd1, 0, 1);
      step(OP_LW, 0, 0, 4'd2, 0, 1);
      step(OP_BEQ, 0, 0, 4'd0, 0, 1);
      // clear_err acts during stall
      step(OP_LW, 1, 1, 4'd0, 0, 0);
      // stall holds off an illegal dispatch
      step(6'h3F, 0, 0, 4'd1, 0, 0);
      step(6'h3F, 1, 0, 4'd1, 0, 0);
      step(6'h3F, 0, 0, 4'd0, 0, 1);
      // SEQ walk to 4'hF, then SEQ from 4'hF is an error without retire
      step(OP_J, 0, 1, 4'd1, 0, 0);
      seq_force = 1'b1;
      for (int k = 2; k <= 15; k++)
         step(OP_J, 0, 0, 4'(k), 0, 0);
      step(OP_J, 0, 0, 4'd0, 0, 1);
      seq_force = 1'b0;
      step(OP_J, 0, 1, 4'd1, 0, 0);
      step(OP_J, 0, 0, 4'd9, 0, 0);
      step(OP_J, 0, 0, 4'd0, 1, 0);
      // saturation: 11 more retires push the count past 4'hF
      for (int n = 0; n < 11; n++) begin
         step(OP_J, 0, 0, 4'd1, 0, 0);
         step(OP_J, 0, 0, 4'd9, 0, 0);
         step(OP_J, 0, 0, 4'd0, 1, 0);
      end
      // set illegal, then R-type into state 7 and reset asynchronously there
      step(6'h3F, 0, 0, 4'd1, 0, 0);
      step(6'h3F, 0, 0, 4'd0, 0, 1);
      step(OP_RTYPE, 0, 0, 4'd1, 0, 1);
      step(OP_RTYPE, 0, 0, 4'd6, 0, 1);
      step(OP_RTYPE, 0, 0, 4'd7, 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_state", bus.state, 4'd0);
      chk("async_count", bus.retired_count, 4'd0);
      chk("async_illegal", bus.illegal_op, 1'b0);
      chk("async_done", bus.instr_done, 1'b0);
      @(negedge clk);
      chk("held_reset_done", bus.instr_done, 1'b0);
      rst_n = 1'b1;
      exp_cnt = '0;
      // restart after reset: lw retires as the first instruction
      step(OP_LW, 0, 0, 4'd1, 0, 0);
      step(OP_LW, 0, 0, 4'd2, 0, 0);
      step(OP_LW, 0, 0, 4'd3, 0, 0);
      step(OP_LW, 0, 0, 4'd4, 0, 0);
      step(OP_LW, 0, 0, 4'd0, 1, 0);
      @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
